// File: rtl/fir_mac_core.sv
// Sequential-MAC FIR datapath: one tap per cycle, rounded/shifted result on a valid/ready port.
// Optional build macro FIR_SAT_EN clamps out-of-range results instead of wrapping.
module fir_mac_core #(
  parameter int NTAPS = 8,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int OW    = 16,
  parameter int SHIFT = 15
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [CW-1:0]            coef_wdata,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DW-1:0]            s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [OW-1:0]            m_data,
  output logic                     busy,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int AW   = $clog2(NTAPS);
  localparam int PW   = DW + CW;
  localparam int ACCW = DW + CW + AW;
  localparam int RW   = ACCW + 1;

  localparam logic signed [RW-1:0] OMAX = {{(RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [RW-1:0] OMIN = {{(RW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  localparam logic signed [RW-1:0] RND  =
    (SHIFT == 0) ? '0 : (RW'(1) << ((SHIFT == 0) ? 0 : SHIFT - 1));
  localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                 state;
  logic signed [DW-1:0]   x [NTAPS];
  logic signed [CW-1:0]   c [NTAPS];
  logic signed [ACCW-1:0] acc;
  logic [AW-1:0]          k;

  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [RW-1:0]   rsum;
  logic signed [RW-1:0]   r;
  logic                   over;
  logic [OW-1:0]          res;
  logic                   ovf_set;
  logic                   addr_ok;

  always_comb begin
    prod     = x[k] * c[k];
    prod_ext = {{AW{prod[PW-1]}}, prod};
    rsum     = {acc[ACCW-1], acc} + RND;
    r        = rsum >>> SHIFT;
    over     = (r > OMAX) || (r < OMIN);
`ifdef FIR_SAT_EN
    if (r > OMAX)      res = OMAX[OW-1:0];
    else if (r < OMIN) res = OMIN[OW-1:0];
    else               res = r[OW-1:0];
`else
    res = r[OW-1:0];
`endif
    // result is registered on the first OUT cycle, which is when ovf is evaluated
    ovf_set = (state == OUT) && !m_valid && over;
    addr_ok = 32'(coef_addr) < NTAPS;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= IDLE;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
      acc     <= '0;
      k       <= '0;
      for (int unsigned i = 0; i < NTAPS; i++) begin
        x[i] <= '0;
        c[i] <= '0;
      end
    end else begin
      ovf <= ovf_set | (ovf & ~ovf_clr);
      case (state)
        IDLE: begin
          if (coef_we && addr_ok) c[coef_addr] <= coef_wdata;
          if (s_valid && s_ready) begin
            x[0] <= s_data;
            for (int unsigned i = 1; i < NTAPS; i++) x[i] <= x[i-1];
            acc     <= '0;
            k       <= '0;
            s_ready <= 1'b0;
            busy    <= 1'b1;
            state   <= MAC;
          end else begin
            s_ready <= 1'b1;
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          k   <= k + 1'b1;
          if (k == LAST) state <= OUT;
        end
        OUT: begin
          if (!m_valid) begin
            m_valid <= 1'b1;
            m_data  <= res;
          end else if (m_ready) begin
            m_valid <= 1'b0;
            busy    <= 1'b0;
            s_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
